freq_divider_pwm: RTL and testbench

- Multi-channel programmable clock divider / PWM generator for the telemeter, replacing the fixed single-output divider.
- Each channel has a period and high-time programmable at run time, a polarity and a mode:
  - continuous mode: clock or PWM output;
  - one-shot mode: a single pulse of a set length, e.g. the ultrasonic trigger pulse.
- Sits between the system clock and the sensor/display timing logic. Configuration is written through a simple strobe interface.

---
 rtl/freq_div_pkg.sv | 17 +
 rtl/freq_div_channel.sv | 91 +++++++++
 rtl/freq_divider_pwm.sv | 59 +++++
 tb/tb_freq_divider_pwm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared types and constants for the divider / PWM channels
package freq_div_pkg;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Storage width of config fields; channels use the low CNT_W bits (CNT_W <= CFG_CNT_W)
  localparam int CFG_CNT_W = 16;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] period;
    logic [CFG_CNT_W-1:0] ton;
    logic                 mode;
    logic                 pol;
  } chan_cfg_t;

endpackage

// File: rtl/freq_div_channel.sv
// rtl/freq_div_channel.sv - one divider / PWM / one-shot channel with shadowed config
module freq_div_channel
  import freq_div_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter int   DEF_NBT   = 10,
  parameter int   DEF_NBTON = 5,
  parameter logic POLARITY  = 1'b1
) (
  input  logic      clkIn,
  input  logic      resetN,
  input  logic      wrSel,
  input  chan_cfg_t wrCfg,
  input  logic      chEn,
  input  logic      start,
  output logic      clkOut,
  output logic      periodTick,
  output logic      busy
);

  localparam chan_cfg_t DEF_CFG = '{
    period: CFG_CNT_W'(DEF_NBT),
    ton:    CFG_CNT_W'(DEF_NBTON),
    mode:   MODE_CONT,
    pol:    POLARITY
  };

  chan_cfg_t        active;
  chan_cfg_t        shadow;
  logic             pending;
  logic             oneShotRun;
  logic [CNT_W-1:0] cnt;

  chan_cfg_t        nextShadow;
  chan_cfg_t        cfgNow;
  logic             nextPending;
  logic             idle;
  logic             run;
  logic             wrap;
  logic [CNT_W-1:0] perNow;
  logic [CNT_W-1:0] tonNow;
  logic [CNT_W-1:0] lastCnt;

  // While idle the channel has no period in flight, so the shadow config is live immediately
  always_comb begin
    nextShadow  = wrSel ? wrCfg : shadow;
    nextPending = wrSel | pending;
    idle        = !chEn || ((active.mode == MODE_ONESHOT) && !oneShotRun);
    cfgNow      = idle ? nextShadow : active;
    perNow      = cfgNow.period[CNT_W-1:0];
    tonNow      = cfgNow.ton[CNT_W-1:0];
    lastCnt     = (perNow == '0) ? '0 : perNow - CNT_W'(1);
    wrap        = (cnt == lastCnt);
    run         = chEn && ((cfgNow.mode == MODE_CONT) || oneShotRun || start);
  end

  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      active     <= DEF_CFG;
      shadow     <= DEF_CFG;
      pending    <= 1'b0;
      oneShotRun <= 1'b0;
      cnt        <= '0;
      clkOut     <= ~POLARITY;
      periodTick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      shadow  <= nextShadow;
      pending <= nextPending;
      if (idle || (run && wrap)) begin
        active  <= nextShadow;
        pending <= 1'b0;
      end
      if (run) begin
        clkOut     <= (cnt < tonNow) ? cfgNow.pol : ~cfgNow.pol;
        cnt        <= wrap ? '0 : cnt + CNT_W'(1);
        periodTick <= wrap;
        // internal run flag drops on the last cycle so a held start re-arms with no gap
        oneShotRun <= (cfgNow.mode == MODE_ONESHOT) && !wrap;
        busy       <= (cfgNow.mode == MODE_ONESHOT);
      end else begin
        clkOut     <= ~cfgNow.pol;
        cnt        <= '0;
        periodTick <= 1'b0;
        oneShotRun <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_divider_pwm.sv
// rtl/freq_divider_pwm.sv - multi-channel programmable clock divider / PWM generator
module freq_divider_pwm
  import freq_div_pkg::*;
#(
  parameter int   NCH       = 2,
  parameter int   CNT_W     = 16,
  parameter int   DEF_NBT   = 10,
  parameter int   DEF_NBTON = 5,
  parameter logic POLARITY  = 1'b1,
  parameter int   CH_W      = 4
) (
  input  logic             clkIn,
  input  logic             resetN,
  input  logic             wrEn,
  input  logic [CH_W-1:0]  wrCh,
  input  logic [CNT_W-1:0] wrPeriod,
  input  logic [CNT_W-1:0] wrTon,
  input  logic             wrMode,
  input  logic             wrPol,
  input  logic [NCH-1:0]   chEn,
  input  logic [NCH-1:0]   start,
  output logic [NCH-1:0]   clkOut,
  output logic [NCH-1:0]   periodTick,
  output logic [NCH-1:0]   busy
);

  chan_cfg_t wrCfg;

  assign wrCfg = '{
    period: CFG_CNT_W'(wrPeriod),
    ton:    CFG_CNT_W'(wrTon),
    mode:   wrMode,
    pol:    wrPol
  };

  // Only indices below NCH decode, so out-of-range writes fall through untouched
  for (genvar i = 0; i < NCH; i++) begin : gCh
    logic wrSel;
    assign wrSel = wrEn && (wrCh == CH_W'(i));

    freq_div_channel #(
      .CNT_W     (CNT_W),
      .DEF_NBT   (DEF_NBT),
      .DEF_NBTON (DEF_NBTON),
      .POLARITY  (POLARITY)
    ) uChannel (
      .clkIn      (clkIn),
      .resetN     (resetN),
      .wrSel      (wrSel),
      .wrCfg      (wrCfg),
      .chEn       (chEn[i]),
      .start      (start[i]),
      .clkOut     (clkOut[i]),
      .periodTick (periodTick[i]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_freq_divider_pwm.sv
// tb/tb_freq_divider_pwm.sv - self-checking bench for freq_divider_pwm
module tb_freq_divider_pwm;

  localparam int NCH   = 2;
  localparam int CNT_W = 16;
  localparam int CH_W  = 4;

  logic             clkIn    = 1'b0;
  logic             resetN   = 1'b0;
  logic             wrEn     = 1'b0;
  logic [CH_W-1:0]  wrCh     = '0;
  logic [CNT_W-1:0] wrPeriod = '0;
  logic [CNT_W-1:0] wrTon    = '0;
  logic             wrMode   = 1'b0;
  logic             wrPol    = 1'b0;
  logic [NCH-1:0]   chEn     = '0;
  logic [NCH-1:0]   start    = '0;
  logic [NCH-1:0]   clkOut;
  logic [NCH-1:0]   periodTick;
  logic [NCH-1:0]   busy;

  freq_divider_pwm #(
    .NCH       (NCH),
    .CNT_W     (CNT_W),
    .DEF_NBT   (10),
    .DEF_NBTON (5),
    .POLARITY  (1'b1),
    .CH_W      (CH_W)
  ) dut (
    .clkIn      (clkIn),
    .resetN     (resetN),
    .wrEn       (wrEn),
    .wrCh       (wrCh),
    .wrPeriod   (wrPeriod),
    .wrTon      (wrTon),
    .wrMode     (wrMode),
    .wrPol      (wrPol),
    .chEn       (chEn),
    .start      (start),
    .clkOut     (clkOut),
    .periodTick (periodTick),
    .busy       (busy)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    int    ch;
    logic  eClk;
    logic  eTick;
    logic  eBusy;
    string tag;
  } exp_t;

  typedef struct {
    int          p;
    int          t;
    logic        pol;
    logic [11:0] clkPat;
    logic [11:0] tickPat;
  } vec_t;

  exp_t expQ[$];
  vec_t vt[8];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setWr(input int ch, input int p, input int t, input logic m, input logic pol);
    wrEn     = 1'b1;
    wrCh     = CH_W'(ch);
    wrPeriod = CNT_W'(p);
    wrTon    = CNT_W'(t);
    wrMode   = m;
    wrPol    = pol;
  endtask

  // Queue the expectation for the next edge, let the edge happen, then compare
  task automatic cyc(input int ch, input logic eClk, input logic eTick, input logic eBusy,
                     input string tag);
    exp_t e;
    exp_t r;
    e = '{ch, eClk, eTick, eBusy, tag};
    expQ.push_back(e);
    @(negedge clkIn);
    wrEn = 1'b0;
    r = expQ.pop_front();
    check({r.tag, " clkOut"},     32'(clkOut[r.ch]),     32'(r.eClk));
    check({r.tag, " periodTick"}, 32'(periodTick[r.ch]), 32'(r.eTick));
    check({r.tag, " busy"},       32'(busy[r.ch]),       32'(r.eBusy));
  endtask

  initial begin
    vt[0] = '{10, 5, 1'b1, 12'b111110000011, 12'b000000000100};
    vt[1] = '{4,  1, 1'b1, 12'b100010001000, 12'b000100010001};
    vt[2] = '{4,  1, 1'b0, 12'b011101110111, 12'b000100010001};
    vt[3] = '{6,  0, 1'b1, 12'b000000000000, 12'b000001000001};
    vt[4] = '{6,  6, 1'b1, 12'b111111111111, 12'b000001000001};
    vt[5] = '{0,  3, 1'b1, 12'b111111111111, 12'b111111111111};
    vt[6] = '{1,  0, 1'b0, 12'b111111111111, 12'b111111111111};
    vt[7] = '{3,  7, 1'b0, 12'b000000000000, 12'b001001001001};

    // reset state
    repeat (2) @(negedge clkIn);
    check("rst clkOut", 32'(clkOut), 32'(0));
    check("rst periodTick", 32'(periodTick), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    resetN = 1'b1;
    cyc(0, 1'b0, 1'b0, 1'b0, "postRst");

    // default 10/5 pattern
    chEn[0] = 1'b1;
    for (int k = 0; k < 23; k++)
      cyc(0, (k % 10) < 5, (k % 10) == 9, 1'b0, $sformatf("def%0d", k));

    // mid-period reconfiguration waits for the boundary
    setWr(0, 4, 1, 1'b0, 1'b1);
    for (int k = 23; k < 30; k++)
      cyc(0, (k % 10) < 5, (k % 10) == 9, 1'b0, $sformatf("defTail%0d", k));
    for (int k = 0; k < 9; k++)
      cyc(0, (k % 4) == 0, (k % 4) == 3, 1'b0, $sformatf("p4_%0d", k));
    setWr(0, 4, 1, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++)
      cyc(0, 1'b0, k == 3, 1'b0, $sformatf("p4Tail%0d", k));
    for (int k = 0; k < 8; k++)
      cyc(0, (k % 4) != 0, (k % 4) == 3, 1'b0, $sformatf("inv%0d", k));

    // table of boundary configurations, each from a fresh enable
    for (int v = 0; v < 8; v++) begin
      chEn[0] = 1'b0;
      setWr(0, vt[v].p, vt[v].t, 1'b0, vt[v].pol);
      cyc(0, ~vt[v].pol, 1'b0, 1'b0, $sformatf("tblIdle%0d", v));
      chEn[0] = 1'b1;
      for (int k = 0; k < 12; k++)
        cyc(0, vt[v].clkPat[11-k], vt[v].tickPat[11-k], 1'b0, $sformatf("tbl%0d_%0d", v, k));
    end

    // write to channel index NCH is ignored
    chEn = '0;
    setWr(NCH, 2, 1, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b0, 1'b0, "badCh0");
    check("badCh ch1 clkOut", 32'(clkOut[1]), 32'(0));
    cyc(0, 1'b1, 1'b0, 1'b0, "badCh0b");
    chEn[0] = 1'b1;
    for (int k = 0; k < 6; k++)
      cyc(0, 1'b0, (k % 3) == 2, 1'b0, $sformatf("badChRun%0d", k));

    // one-shot on channel 1
    chEn = '0;
    setWr(1, 8, 3, 1'b1, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, "osCfg");
    chEn[1] = 1'b1;
    cyc(1, 1'b0, 1'b0, 1'b0, "osIdle0");
    cyc(1, 1'b0, 1'b0, 1'b0, "osIdle1");
    for (int k = 0; k < 8; k++) begin
      start[1] = (k == 0) || (k == 3);
      cyc(1, k < 3, k == 7, 1'b1, $sformatf("os%0d", k));
    end
    start[1] = 1'b0;
    for (int k = 0; k < 4; k++)
      cyc(1, 1'b0, 1'b0, 1'b0, $sformatf("osAfter%0d", k));

    // held start re-triggers back to back
    start[1] = 1'b1;
    for (int k = 0; k < 16; k++)
      cyc(1, (k % 8) < 3, (k % 8) == 7, 1'b1, $sformatf("osHeld%0d", k));
    start[1] = 1'b0;
    cyc(1, 1'b0, 1'b0, 1'b0, "osHeldEnd");

    // disable mid-period then full restart
    chEn = '0;
    setWr(0, 10, 5, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0, "disCfg");
    chEn[0] = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc(0, 1'b1, 1'b0, 1'b0, $sformatf("disPre%0d", k));
    chEn[0] = 1'b0;
    cyc(0, 1'b0, 1'b0, 1'b0, "dis0");
    cyc(0, 1'b0, 1'b0, 1'b0, "dis1");
    chEn[0] = 1'b1;
    for (int k = 0; k < 10; k++)
      cyc(0, k < 5, k == 9, 1'b0, $sformatf("reen%0d", k));

    // asynchronous reset in the middle of a one-shot
    chEn = 2'b10;
    start[1] = 1'b1;
    cyc(1, 1'b1, 1'b0, 1'b1, "rstOs0");
    start[1] = 1'b0;
    cyc(1, 1'b1, 1'b0, 1'b1, "rstOs1");
    resetN = 1'b0;
    #1;
    check("asyncRst clkOut", 32'(clkOut), 32'(0));
    check("asyncRst busy", 32'(busy), 32'(0));
    check("asyncRst periodTick", 32'(periodTick), 32'(0));
    @(negedge clkIn);
    resetN = 1'b1;
    for (int k = 0; k < 10; k++)
      cyc(1, k < 5, k == 9, 1'b0, $sformatf("rstDef%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
